piso_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit parallel-in/serial-out serializer between up to NUM_REQ requesters. Each requester gets a one-entry holding buffer with a valid/ready handshake. The arbiter issues one word at a time into the serializer, counts the serial bits coming back, and tags the serial stream with the owning requester ID. It sits directly in front of the serializer and drives its `valid_i`/`parallel_i` inputs.

---
 rtl/piso_arbiter.sv | 112 +++++++++++
 tb/tb_piso_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_arbiter.sv
// Round-robin arbiter that feeds one shared parallel-in/serial-out serializer
// from NUM_REQ single-entry holding buffers and tags the serial stream with its owner.
module piso_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      piso_valid_o,
  output logic [DATA_W-1:0]         piso_parallel_o,
  input  logic                      piso_empty_i,
  input  logic                      piso_valid_i,
  output logic [ID_W-1:0]           owner_o,
  output logic                      owner_valid_o,
  output logic                      busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SHIFT} state_t;

  state_t                    state_reg, state_next;
  logic [NUM_REQ-1:0]        pend_reg, pend_next;
  logic [NUM_REQ*DATA_W-1:0] buf_reg, buf_next;
  logic [ID_W-1:0]           grant_reg, grant_next;
  logic [ID_W-1:0]           last_reg, last_next;
  logic [CNT_W-1:0]          bitcnt_reg, bitcnt_next;
  logic [NUM_REQ-1:0]        accept;
  logic [NUM_REQ-1:0]        issue_clr;
  logic [ID_W-1:0]           pick;
  logic                      found;

  // Per-requester holding buffer; the issuing buffer is freed at the end of ISSUE.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign accept[gi]    = req_valid_i[gi] & ~pend_reg[gi];
    assign issue_clr[gi] = (state_reg == ISSUE) && (grant_reg == ID_W'(gi));
    assign pend_next[gi] = ~issue_clr[gi] & (pend_reg[gi] | accept[gi]);
    assign buf_next[gi*DATA_W +: DATA_W] = accept[gi] ? req_data_i[gi*DATA_W +: DATA_W]
                                                      : buf_reg[gi*DATA_W +: DATA_W];
  end

  // Scan from the farthest offset down so the nearest pending requester after last wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (pend_reg[ID_W'((int'(last_reg) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = ID_W'((int'(last_reg) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    last_next   = last_reg;
    bitcnt_next = bitcnt_reg;
    case (state_reg)
      IDLE: begin
        if (found && piso_empty_i) begin
          grant_next = pick;
          last_next  = pick;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bitcnt_next = '0;
        state_next  = SHIFT;
      end
      SHIFT: begin
        if (piso_valid_i) begin
          bitcnt_next = bitcnt_reg + 1'b1;
          if (bitcnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      pend_reg   <= '0;
      buf_reg    <= '0;
      grant_reg  <= '0;
      last_reg   <= ID_W'(NUM_REQ - 1);
      bitcnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      buf_reg    <= buf_next;
      grant_reg  <= grant_next;
      last_reg   <= last_next;
      bitcnt_reg <= bitcnt_next;
    end
  end

  assign req_ready_o     = ~pend_reg;
  assign piso_valid_o    = (state_reg == ISSUE);
  assign piso_parallel_o = (state_reg == ISSUE) ? buf_reg[int'(grant_reg)*DATA_W +: DATA_W] : '0;
  assign owner_o         = (state_reg == SHIFT) ? grant_reg : '0;
  assign owner_valid_o   = (state_reg == SHIFT) & piso_valid_i;
  assign busy_o          = (state_reg != IDLE);

endmodule

// File: tb/tb_piso_arbiter.sv
// Directed bench for piso_arbiter: cycle table for a single word plus
// hand-written round-robin, pacing, empty-gating and reset-in-flight sequences.
module tb_piso_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        piso_valid_o;
  logic [3:0]  piso_parallel_o;
  logic        piso_empty_i;
  logic        piso_valid_i;
  logic [1:0]  owner_o;
  logic        owner_valid_o;
  logic        busy_o;

  piso_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .piso_valid_o(piso_valid_o), .piso_parallel_o(piso_parallel_o),
    .piso_empty_i(piso_empty_i), .piso_valid_i(piso_valid_i),
    .owner_o(owner_o), .owner_valid_o(owner_valid_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ser_bits = 0;
  bit auto_ser = 1'b1;
  logic [3:0] word_q[$];
  logic [1:0] owner_q[$];

  typedef struct packed {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [3:0]  exp_ready;
    logic        exp_pvalid;
    logic [3:0]  exp_par;
    logic [1:0]  exp_owner;
    logic        exp_ov;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: serializer model (load-to-first-bit latency 1) then output monitor.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ser) begin
      if (piso_valid_o) begin
        ser_bits = 4;
        piso_valid_i = 1'b0;
        piso_empty_i = 1'b0;
      end else if (ser_bits > 0) begin
        ser_bits--;
        piso_valid_i = 1'b1;
        piso_empty_i = 1'b0;
      end else begin
        piso_valid_i = 1'b0;
        piso_empty_i = 1'b1;
      end
    end
    #1;
    if (piso_valid_o) word_q.push_back(piso_parallel_o);
    if (owner_valid_o) owner_q.push_back(owner_o);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    req_valid_i = '0;
    auto_ser = 1'b1;
    ser_bits = 0;
    piso_valid_i = 1'b0;
    piso_empty_i = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    word_q.delete();
    owner_q.delete();
  endtask

  task automatic drain(input int n_words, input int max_cyc);
    int n = 0;
    while ((word_q.size() < n_words || owner_q.size() < 4 * n_words || busy_o) && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [3:0] exp_words[$];
    logic [1:0] exp_ids[$];
    int bp;
    int pv_cnt;
    int hold;
    int bad_owner;

    // Single-word cycle table: requester 2 sends 4'hA
    tbl[0] = '{4'b0100, 16'h0A00, 4'b1011, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'b0000, 16'h0000, 4'b1011, 1'b1, 4'hA, 2'd0, 1'b0, 1'b1};
    tbl[2] = '{4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1};
    tbl[3] = '{4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1};
    tbl[4] = '{4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1};
    tbl[5] = '{4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1};
    tbl[6] = '{4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};

    // Reset with all requesters valid
    reset = 1'b0;
    req_valid_i = 4'hF;
    req_data_i = 16'hFFFF;
    piso_valid_i = 1'b0;
    piso_empty_i = 1'b1;
    tick();
    tick();
    chk("reset_ready", req_ready_o, 4'hF);
    chk("reset_pvalid", piso_valid_o, 0);
    chk("reset_par", piso_parallel_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_owner", owner_o, 0);
    chk("reset_ov", owner_valid_o, 0);
    req_valid_i = '0;
    reset = 1'b1;
    tick();
    chk("reset_no_accept", req_ready_o, 4'hF);
    chk("reset_idle", busy_o, 0);
    word_q.delete();
    owner_q.delete();

    for (int r = 0; r < 7; r++) begin
      req_valid_i = tbl[r].valid;
      req_data_i = tbl[r].data;
      tick();
      chk($sformatf("single_r%0d_ready", r), req_ready_o, tbl[r].exp_ready);
      chk($sformatf("single_r%0d_pvalid", r), piso_valid_o, tbl[r].exp_pvalid);
      if (tbl[r].exp_pvalid) chk($sformatf("single_r%0d_par", r), piso_parallel_o, tbl[r].exp_par);
      chk($sformatf("single_r%0d_owner", r), owner_o, tbl[r].exp_owner);
      chk($sformatf("single_r%0d_ov", r), owner_valid_o, tbl[r].exp_ov);
      chk($sformatf("single_r%0d_busy", r), busy_o, tbl[r].exp_busy);
    end
    chk("single_bits", owner_q.size(), 4);

    // Round robin with requester 0 reloading during the first SHIFT
    reset_dut();
    req_valid_i = 4'hF;
    req_data_i = 16'h4321;
    tick();
    req_valid_i = '0;
    chk("rr_all_pending", req_ready_o, 4'h0);
    hold = 0;
    while (word_q.size() < 1 && hold < 20) begin
      tick();
      hold++;
    end
    chk("rr_first_issue", word_q.size(), 1);
    tick();
    chk("rr_shift_ready0", req_ready_o, 4'b0001);
    req_valid_i = 4'b0001;
    req_data_i = 16'h0005;
    tick();
    req_valid_i = '0;
    chk("rr_reload_ready", req_ready_o, 4'h0);
    drain(5, 200);
    exp_words = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    chk("rr_words", word_q.size(), 5);
    chk("rr_bits", owner_q.size(), 20);
    for (int w = 0; w < 5; w++) begin
      if (w < word_q.size()) chk($sformatf("rr_word%0d", w), word_q[w], exp_words[w]);
      if (4 * w + 3 < owner_q.size()) begin
        for (int b = 0; b < 4; b++) chk($sformatf("rr_owner%0d_b%0d", w, b), owner_q[4*w+b], exp_ids[w]);
      end
    end

    // Paced stream from requester 0 at periods 5, 4, 3
    reset_dut();
    exp_words.delete();
    bp = 0;
    for (int g = 0; g < 3; g++) begin
      for (int w = 0; w < 6; w++) begin
        logic [3:0] wd;
        wd = 4'($urandom_range(0, 15));
        exp_words.push_back(wd);
        req_valid_i = 4'b0001;
        req_data_i = {12'h000, wd};
        hold = 0;
        while (!req_ready_o[0] && hold < 50) begin
          tick();
          bp++;
          hold++;
        end
        tick();
        req_valid_i = '0;
        for (int k = 1; k < 5 - g; k++) tick();
      end
    end
    drain(18, 400);
    chk("paced_words", word_q.size(), 18);
    chk("paced_bits", owner_q.size(), 72);
    chk("paced_backpressure", (bp > 0) ? 1 : 0, 1);
    for (int w = 0; w < 18; w++) begin
      if (w < word_q.size()) chk($sformatf("paced_word%0d", w), word_q[w], exp_words[w]);
    end
    bad_owner = 0;
    foreach (owner_q[i]) if (owner_q[i] != 2'd0) bad_owner++;
    chk("paced_owner", bad_owner, 0);

    // Empty gating: serializer busy for 10 cycles with requester 1 pending
    reset_dut();
    auto_ser = 1'b0;
    piso_empty_i = 1'b0;
    piso_valid_i = 1'b0;
    req_valid_i = 4'b0010;
    req_data_i = 16'h0070;
    tick();
    req_valid_i = '0;
    pv_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (piso_valid_o) pv_cnt++;
    end
    chk("gate_no_issue", pv_cnt, 0);
    chk("gate_pend_held", req_ready_o, 4'b1101);
    piso_empty_i = 1'b1;
    auto_ser = 1'b1;
    tick();
    chk("gate_issue", piso_valid_o, 1);
    chk("gate_par", piso_parallel_o, 4'h7);
    drain(1, 30);
    chk("gate_bits", owner_q.size(), 4);

    // Reset in the middle of SHIFT with another requester pending
    reset_dut();
    req_valid_i = 4'b1001;
    req_data_i = 16'h900C;
    tick();
    req_valid_i = '0;
    hold = 0;
    while (owner_q.size() < 2 && hold < 30) begin
      tick();
      hold++;
    end
    chk("rst_mid_bits", owner_q.size(), 2);
    reset = 1'b0;
    auto_ser = 1'b0;
    piso_valid_i = 1'b1;
    piso_empty_i = 1'b1;
    tick();
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_ready", req_ready_o, 4'hF);
    chk("rst_mid_ov", owner_valid_o, 0);
    reset = 1'b1;
    pv_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (piso_valid_o || owner_valid_o || busy_o) pv_cnt++;
    end
    chk("rst_mid_quiet", pv_cnt, 0);
    chk("rst_mid_ready_after", req_ready_o, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
